// File: rtl/logs_nco_bank.sv
// Multi-channel NCO bank: CH phase accumulators driving pulse outputs plus a registered popcount mix.
// Optional macro LOGS_NCO_DUTY_EN adds per-channel duty registers (otherwise fixed 50% from the phase MSB).
module logs_nco_bank #(
   parameter  int N  = 8,
   parameter  int CH = 4,
   localparam int CW = (CH > 1) ? $clog2(CH) : 1,
   localparam int MW = $clog2(CH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          step,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_ch,
   input  logic [1:0]    wr_sel,
   input  logic [N-1:0]  wr_data,
   output logic [CH-1:0] snd,
   output logic [MW-1:0] mix
);

   logic [N-1:0]  phase_q [CH];
   logic [N-1:0]  phase_d [CH];
   logic [N-2:0]  freq_q  [CH];
   logic [N-2:0]  freq_d  [CH];
`ifdef LOGS_NCO_DUTY_EN
   logic [N-1:0]  duty_q  [CH];
   logic [N-1:0]  duty_d  [CH];
`else
   logic          unused_wr_msb;
   assign unused_wr_msb = wr_data[N-1];
`endif
   logic [CH-1:0] en_q, en_d;
   logic [CH-1:0] snd_q, snd_d;
   logic [MW-1:0] mix_q, mix_d;
   logic [CH-1:0] hit, sync;
   logic          wr_ok;

   assign wr_ok = wr_en && (int'(wr_ch) < CH);

   always_comb begin
      en_d  = en_q;
      snd_d = snd_q;
      hit   = '0;
      sync  = '0;
      mix_d = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         mix_d = mix_d + MW'(snd_q[i]);
      end
      for (int unsigned i = 0; i < CH; i++) begin
         phase_d[i] = phase_q[i];
         freq_d[i]  = freq_q[i];
`ifdef LOGS_NCO_DUTY_EN
         duty_d[i]  = duty_q[i];
`endif
         hit[i]  = wr_ok && (wr_ch == CW'(i));
         sync[i] = hit[i] && (wr_sel == 2'd2) && wr_data[1];
         if (hit[i] && (wr_sel == 2'd0)) freq_d[i] = wr_data[N-2:0];
`ifdef LOGS_NCO_DUTY_EN
         if (hit[i] && (wr_sel == 2'd1)) duty_d[i] = wr_data;
`endif
         if (hit[i] && (wr_sel == 2'd2)) en_d[i] = wr_data[0];
         // Sync beats stepping; a disabled channel is silenced even without a step.
         if (sync[i]) begin
            phase_d[i] = '0;
            snd_d[i]   = 1'b0;
         end else if (!en_q[i]) begin
            snd_d[i]   = 1'b0;
         end else if (step) begin
`ifdef LOGS_NCO_DUTY_EN
            snd_d[i]   = (phase_q[i] >= duty_q[i]);
`else
            snd_d[i]   = phase_q[i][N-1];
`endif
            phase_d[i] = phase_q[i] + {1'b0, freq_q[i]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH; i++) begin
            phase_q[i] <= '0;
            freq_q[i]  <= '0;
`ifdef LOGS_NCO_DUTY_EN
            duty_q[i]  <= {1'b1, {(N-1){1'b0}}};
`endif
         end
         en_q  <= '1;
         snd_q <= '0;
         mix_q <= '0;
      end else begin
         for (int unsigned i = 0; i < CH; i++) begin
            phase_q[i] <= phase_d[i];
            freq_q[i]  <= freq_d[i];
`ifdef LOGS_NCO_DUTY_EN
            duty_q[i]  <= duty_d[i];
`endif
         end
         en_q  <= en_d;
         snd_q <= snd_d;
         mix_q <= mix_d;
      end
   end

   assign snd = snd_q;
   assign mix = mix_q;

endmodule

// File: tb/tb_logs_nco_bank.sv
// Directed self-checking bench for logs_nco_bank (N=8, CH=4); follows LOGS_NCO_DUTY_EN if defined.
module tb_logs_nco_bank;

   localparam int N  = 8;
   localparam int CH = 4;
   localparam int CW = 2;
   localparam int MW = 3;

   logic          clk;
   logic          rst_n;
   logic          step;
   logic          wr_en;
   logic [CW-1:0] wr_ch;
   logic [1:0]    wr_sel;
   logic [N-1:0]  wr_data;
   logic [CH-1:0] snd;
   logic [MW-1:0] mix;

   int checks = 0;
   int errors = 0;

   logs_nco_bank #(.N(N), .CH(CH)) dut (
      .clk(clk), .rst_n(rst_n), .step(step), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_sel(wr_sel), .wr_data(wr_data), .snd(snd), .mix(mix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [CW-1:0] ch, input logic [1:0] sel, input logic [N-1:0] data, input logic stp);
      wr_en = 1'b1; wr_ch = ch; wr_sel = sel; wr_data = data; step = stp;
      tick();
      wr_en = 1'b0; wr_sel = '0; wr_data = '0; step = 1'b0;
   endtask

   task automatic do_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step = ~step;
         tick();
         checks++;
         if (snd !== 4'b0000 || mix !== 3'd0) begin
            errors++; $display("FAIL reset_hold%0d snd=%b mix=%0d exp snd=0000 mix=0", i, snd, mix);
         end
      end
      rst_n = 1'b1;
      step  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (snd !== 4'b0000 || mix !== 3'd0) begin
            errors++; $display("FAIL reset_release%0d snd=%b mix=%0d exp snd=0000 mix=0", i, snd, mix);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_square();
      logic e;
      wr(0, 2'd0, 8'd16, 1'b0);
      step = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         e = (((16 * (k - 1)) % 256) >= 128);
         checks++;
         if (snd[0] !== e) begin
            errors++; $display("FAIL square_k%0d snd0=%b exp=%b", k, snd[0], e);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_duty();
      logic e;
      int   highs;
      int   thr;
`ifdef LOGS_NCO_DUTY_EN
      thr = 192;
`else
      thr = 128;
`endif
      highs = 0;
      wr(1, 2'd2, 8'h03, 1'b0);
      wr(1, 2'd0, 8'd32, 1'b0);
      wr(1, 2'd1, 8'd192, 1'b0);
      step = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         e = (((32 * (k - 1)) % 256) >= thr);
         if (snd[1]) highs++;
         checks++;
         if (snd[1] !== e) begin
            errors++; $display("FAIL duty_k%0d snd1=%b exp=%b", k, snd[1], e);
         end
      end
      step = 1'b0;
      checks++;
      if (highs != ((thr == 192) ? 4 : 8)) begin
         errors++; $display("FAIL duty_count highs=%0d exp=%0d", highs, (thr == 192) ? 4 : 8);
      end
   endtask

   task automatic test_sync_enable();
      logic e;
      for (int k = 0; k < 10; k++) do_step();
      checks++;
      if (snd[0] !== 1'b1) begin
         errors++; $display("FAIL sync_pre snd0=%b exp=1", snd[0]);
      end
      wr(0, 2'd2, 8'h03, 1'b1);
      checks++;
      if (snd[0] !== 1'b0) begin
         errors++; $display("FAIL sync_edge snd0=%b exp=0", snd[0]);
      end
      for (int k = 1; k <= 10; k++) begin
         do_step();
         e = ((16 * (k - 1)) >= 128);
         checks++;
         if (snd[0] !== e) begin
            errors++; $display("FAIL sync_resume_k%0d snd0=%b exp=%b", k, snd[0], e);
         end
      end
      wr(0, 2'd2, 8'h00, 1'b0);
      checks++;
      if (snd[0] !== 1'b1) begin
         errors++; $display("FAIL dis_write_edge snd0=%b exp=1", snd[0]);
      end
      for (int k = 1; k <= 11; k++) begin
         do_step();
         checks++;
         if (snd[0] !== 1'b0) begin
            errors++; $display("FAIL dis_k%0d snd0=%b exp=0", k, snd[0]);
         end
      end
      wr(0, 2'd2, 8'h01, 1'b0);
      checks++;
      if (snd[0] !== 1'b0) begin
         errors++; $display("FAIL reen_edge snd0=%b exp=0", snd[0]);
      end
      // Phase held at 160 while disabled: six highs then wrap to 0.
      for (int j = 1; j <= 7; j++) begin
         do_step();
         e = (j <= 6);
         checks++;
         if (snd[0] !== e) begin
            errors++; $display("FAIL reen_k%0d snd0=%b exp=%b", j, snd[0], e);
         end
      end
   endtask

   task automatic test_collision();
      logic [2:0] e3;
      logic [3:0] e4;
      e3 = 3'b100;
      e4 = 4'b1001;
      wr(2, 2'd2, 8'h03, 1'b0);
      wr(2, 2'd0, 8'd64, 1'b1);
      checks++;
      if (snd[2] !== 1'b0) begin
         errors++; $display("FAIL coll_edge snd2=%b exp=0", snd[2]);
      end
      for (int k = 0; k < 3; k++) begin
         do_step();
         checks++;
         if (snd[2] !== e3[k]) begin
            errors++; $display("FAIL coll_k%0d snd2=%b exp=%b", k + 1, snd[2], e3[k]);
         end
      end
      wr(2, 2'd3, 8'h02, 1'b0);
      wr(2, 2'd3, 8'h00, 1'b0);
      checks++;
      if (snd[2] !== 1'b1) begin
         errors++; $display("FAIL resv_hold snd2=%b exp=1", snd[2]);
      end
      for (int k = 0; k < 4; k++) begin
         do_step();
         checks++;
         if (snd[2] !== e4[k]) begin
            errors++; $display("FAIL resv_k%0d snd2=%b exp=%b", k + 1, snd[2], e4[k]);
         end
      end
   endtask

   task automatic test_mix();
      for (int c = 0; c < CH; c++) wr(CW'(c), 2'd2, 8'h03, 1'b0);
`ifdef LOGS_NCO_DUTY_EN
      for (int c = 0; c < CH; c++) begin
         wr(CW'(c), 2'd0, 8'd0, 1'b0);
         wr(CW'(c), 2'd1, 8'd0, 1'b0);
      end
`else
      for (int c = 0; c < CH; c++) wr(CW'(c), 2'd0, 8'd64, 1'b0);
      do_step();
      do_step();
      for (int c = 0; c < CH; c++) wr(CW'(c), 2'd0, 8'd0, 1'b0);
`endif
      do_step();
      checks++;
      if (snd !== 4'b1111 || mix !== 3'd0) begin
         errors++; $display("FAIL mix_step snd=%b mix=%0d exp snd=1111 mix=0", snd, mix);
      end
      tick();
      checks++;
      if (mix !== 3'd4) begin
         errors++; $display("FAIL mix_four mix=%0d exp=4", mix);
      end
      wr(3, 2'd2, 8'h00, 1'b0);
      checks++;
      if (snd !== 4'b1111 || mix !== 3'd4) begin
         errors++; $display("FAIL mix_dis0 snd=%b mix=%0d exp snd=1111 mix=4", snd, mix);
      end
      tick();
      checks++;
      if (snd !== 4'b0111 || mix !== 3'd4) begin
         errors++; $display("FAIL mix_dis1 snd=%b mix=%0d exp snd=0111 mix=4", snd, mix);
      end
      tick();
      checks++;
      if (mix !== 3'd3) begin
         errors++; $display("FAIL mix_dis2 mix=%0d exp=3", mix);
      end
   endtask

   task automatic test_reset_mid();
      logic e;
      rst_n = 1'b0;
      #1;
      checks++;
      if (snd !== 4'b0000 || mix !== 3'd0) begin
         errors++; $display("FAIL rst_mid snd=%b mix=%0d exp snd=0000 mix=0", snd, mix);
      end
      tick();
      rst_n = 1'b1;
      do_step();
      checks++;
      if (snd !== 4'b0000) begin
         errors++; $display("FAIL rst_first_step snd=%b exp=0000", snd);
      end
      wr(0, 2'd0, 8'd16, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         do_step();
         e = (k == 9);
         checks++;
         if (snd[0] !== e) begin
            errors++; $display("FAIL rst_resume_k%0d snd0=%b exp=%b", k, snd[0], e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; step = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
      test_reset();
      test_square();
      test_duty();
      test_sync_enable();
      test_collision();
      test_mix();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
